reg_dump: RTL and testbench
===========================

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter WIDTH, default 8, data width of one register.
REQ-002 Parameter NREGS, default 8, number of registers in the target register file.
REQ-003 Parameter AW, default 3, address width; the block SHALL require NREGS <= 2**AW.
REQ-004 clk  in  1  single clock; all state changes on the posedge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  request to begin a dump; sampled only in IDLE.
REQ-007 abort  in  1  cancels a dump in progress.
REQ-008 first_addr  in  AW  first register address, sampled with start.
REQ-009 last_addr  in  AW  last register address, sampled with start.
REQ-010 rd_addr  out  AW  register-file read address; the register file returns data combinationally.
REQ-011 rd_data  in  WIDTH  register-file read data for rd_addr.
REQ-012 out_data  out  WIDTH  dumped register value.
REQ-013 out_valid  out  1  out_data holds a valid value.
REQ-014 out_ready  in  1  downstream accepts out_data.
REQ-015 out_last  out  1  the current out_data is the final value of the dump.
REQ-016 busy  out  1  a dump is in progress.
REQ-017 done  out  1  one-cycle pulse when a dump completes normally.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, READ, SEND and DONE.
REQ-019 IDLE: start=1 -> READ; rd_addr <= first_addr; latch last_addr as the end address.
REQ-020 If last_addr < first_addr at start, the end address SHALL be first_addr, so exactly one value is dumped.
REQ-021 READ: at the edge, out_data <= rd_data, out_valid <= 1, out_last <= (rd_addr == end address); go to SEND.
REQ-022 SEND: out_valid and out_data SHALL stay stable until out_valid&&out_ready is sampled at an edge.
REQ-023 SEND handshake, not last: rd_addr <= rd_addr+1, out_valid <= 0, go to READ.
REQ-024 SEND handshake, last: out_valid <= 0, go to DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 busy SHALL be 1 in READ and SEND and 0 in IDLE and DONE.
REQ-027 start SHALL be ignored in READ, SEND and DONE.
REQ-028 abort=1 in READ or SEND SHALL force IDLE at the next edge: out_valid=0, out_last=0, no done pulse.
REQ-029 abort SHALL take priority over a simultaneous handshake; abort SHALL be ignored in IDLE and DONE.
REQ-030 Throughput: each value SHALL occupy at least 2 cycles (READ + SEND); latency from start sampled to first out_valid SHALL be 2 edges.
REQ-031 rd_addr SHALL never increment past the end address and SHALL never wrap.

Reset
REQ-032 rst low SHALL immediately give: state IDLE, rd_addr 0, out_data 0, out_valid 0, out_last 0, busy 0, done 0.
REQ-033 Reset asserted mid-dump SHALL discard the dump with no done pulse; after release the block SHALL wait for a new start.

Structure
REQ-034 State encoding, WIDTH/NREGS/AW defaults, and a localparam for the single-read end-address rule SHALL live in shared package reg_dump_pkg.
REQ-035 The address counter SHALL be the sub-module reg_dump_addr_ctr (load, increment, compare-equal to end); the FSM and output registers SHALL remain in reg_dump.

Verification
REQ-036 Register file preloaded with regs[i]=0x10+i, start with first=0, last=7, out_ready=1 -> 8 beats 0x10..0x17, out_last only on 0x17, done one cycle after that beat, 16 busy cycles.
REQ-037 first=2, last=4, out_ready toggled 1-0-1 -> beats 0x12,0x13,0x14 each held stable while out_ready=0, no duplicates or skips.
REQ-038 first=5, last=3 -> exactly one beat 0x15 with out_last=1, then done.
REQ-039 abort during SEND of the 3rd beat with out_ready=1 in the same cycle -> no handshake, out_valid=0 next cycle, state IDLE, no done.
REQ-040 rst asserted mid-dump between clock edges -> all outputs 0 immediately; a new start after release dumps from the newly given first_addr.
REQ-041 start held high continuously -> a new dump begins only on the IDLE cycle after done, never in DONE.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared constants for the register dump engine: parameter defaults,
// FSM state encoding and the end-address policy.
package reg_dump_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREGS = 8;
    localparam int DEF_AW    = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // A reversed range (last < first) collapses to a single read of first.
    localparam bit CLAMP_END_TO_FIRST = 1'b1;
endpackage

// File: rtl/reg_dump_if.sv
// Register-file read port plus the valid/ready output stream of reg_dump.
interface reg_dump_if
    import reg_dump_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
);
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output rd_addr, out_data, out_valid, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_addr, out_data, out_valid, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/reg_dump_addr_ctr.sv
// Read-address counter: loads the start address and end address, steps by
// one on request and saturates at the end address (never wraps).
module reg_dump_addr_ctr
    import reg_dump_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    input  logic [AW-1:0] first,
    input  logic [AW-1:0] last,
    output logic [AW-1:0] addr,
    output logic          at_end
);
    logic [AW-1:0] end_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr  <= '0;
            end_q <= '0;
        end else if (load) begin
            addr  <= first;
            end_q <= (CLAMP_END_TO_FIRST && (last < first)) ? first : last;
        end else if (inc && !at_end) begin
            addr  <= addr + 1'b1;
        end
    end

    assign at_end = (addr == end_q);
endmodule

// File: rtl/reg_dump.sv
// Walks a register file from first_addr to last_addr and streams each value
// out over a valid/ready handshake; abortable, with a done pulse on completion.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    output logic          busy,
    output logic          done,
    reg_dump_if.master    bus
);
    if (NREGS > (1 << AW)) begin : g_nregs_check
        $error("reg_dump: NREGS exceeds 2**AW");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             last_q;
    logic             ctr_load;
    logic             ctr_inc;
    logic             at_end;
    logic [AW-1:0]    addr;

    assign ctr_load = (state == S_IDLE) && start;
    assign ctr_inc  = (state == S_SEND) && !abort && bus.out_ready && !last_q;

    reg_dump_addr_ctr #(.AW(AW)) u_addr_ctr (
        .clk    (clk),
        .rst    (rst),
        .load   (ctr_load),
        .inc    (ctr_inc),
        .first  (first_addr),
        .last   (last_addr),
        .addr   (addr),
        .at_end (at_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_READ;
                S_READ: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else begin
                        data_q  <= bus.rd_data;
                        valid_q <= 1'b1;
                        last_q  <= at_end;
                        state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    // abort wins over a handshake landing on the same edge
                    if (abort) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        state   <= last_q ? S_DONE : S_READ;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_addr   = addr;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign busy          = (state == S_READ) || (state == S_SEND);
    assign done          = (state == S_DONE);
endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: expected beats queued at start, popped and
// compared on each accepted output handshake.
module tb_reg_dump;
    localparam int W = 8;
    localparam int N = 8;
    localparam int A = 3;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [A-1:0]  first_addr = '0;
    logic [A-1:0]  last_addr = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  regs [N];

    reg_dump_if #(.WIDTH(W), .AW(A)) bus ();

    reg_dump #(.WIDTH(W), .NREGS(N), .AW(A)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    assign bus.rd_data = regs[bus.rd_addr];

    beat_t        exp_q[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           hs_cnt = 0;
    int           n_done = 0;
    int           busy_cnt = 0;
    int           last_hs_cyc = 0;
    int           n_stable = 0;
    bit           toggle = 1'b0;
    bit           stable_chk = 1'b0;
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        for (int i = 0; i < N; i++) regs[i] = 8'h10 + W'(i);
        bus.out_ready = 1'b1;
    end

    // Downstream ready: steady high, or a 1-0-1 stall pattern.
    always @(posedge clk) begin
        #1;
        bus.out_ready = toggle ? ((cyc % 3) != 1) : 1'b1;
    end

    // Monitor: inputs settle at posedge+1, so negedge sees what the next edge samples.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (stable_chk && prev_hold && bus.out_valid) begin
                n_stable++;
                chk("stable_data", bus.out_data, prev_data);
            end
            prev_hold = bus.out_valid && !bus.out_ready && !abort;
            prev_data = bus.out_data;
            if (bus.out_valid && bus.out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", bus.out_data, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus.out_data, e.data);
                    chk("beat_last", bus.out_last, e.last);
                end
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                n_done++;
                chk("done_after_last", cyc - last_hs_cyc, 1);
            end
        end
    end

    task automatic push_dump(input int f, input int l);
        int e = (l < f) ? f : l;
        for (int a = f; a <= e; a++) exp_q.push_back('{data: 8'h10 + W'(a), last: (a == e)});
    endtask

    task automatic start_dump(input int f, input int l);
        first_addr = A'(f);
        last_addr  = A'(l);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int d0 = n_done;
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (n_done > d0) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_last"},  bus.out_last, 0);
        chk({tag, "_data"},  bus.out_data, 0);
        chk({tag, "_addr"},  bus.rd_addr, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
    endtask

    initial begin
        int h0, d0;
        #1 rst = 1'b0;
        #1 chk_zero("rst");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // full range, ready always high
        busy_cnt = 0;
        push_dump(0, 7);
        start_dump(0, 7);
        chk("lat_edge1_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("lat_edge2_valid", bus.out_valid, 1);
        wait_done(100);
        chk("full_q_empty", exp_q.size(), 0);
        chk("full_busy_cycles", busy_cnt, 16);
        chk("done_one_cycle", done, 0);

        // sub-range with downstream stalls
        toggle = 1'b1; stable_chk = 1'b1; n_stable = 0;
        push_dump(2, 4);
        start_dump(2, 4);
        wait_done(200);
        toggle = 1'b0; stable_chk = 1'b0;
        chk("stall_q_empty", exp_q.size(), 0);
        chk("stall_seen", (n_stable > 0), 1);

        // reversed range collapses to one beat
        h0 = hs_cnt;
        push_dump(5, 3);
        start_dump(5, 3);
        wait_done(100);
        chk("rev_beats", hs_cnt - h0, 1);
        chk("rev_q_empty", exp_q.size(), 0);

        // abort during SEND of the third beat, ready high in the same cycle
        h0 = hs_cnt; d0 = n_done;
        exp_q.push_back('{data: 8'h10, last: 1'b0});
        exp_q.push_back('{data: 8'h11, last: 1'b0});
        start_dump(0, 7);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid && (hs_cnt - h0) == 2) break;
        end
        chk("abort_in_send", bus.out_valid, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_last", bus.out_last, 0);
        chk("abort_idle", {busy, done}, 2'b00);
        chk("abort_beats", hs_cnt - h0, 2);
        repeat (4) @(posedge clk); #1;
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_q_empty", exp_q.size(), 0);

        // async reset mid-dump, then a fresh dump from a new first_addr
        d0 = n_done;
        push_dump(0, 7);
        start_dump(0, 7);
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk_zero("midrst");
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("postrst_idle", busy, 0);
        push_dump(3, 5);
        start_dump(3, 5);
        wait_done(100);
        chk("postrst_one_done", n_done - d0, 1);
        chk("postrst_q_empty", exp_q.size(), 0);

        // start held high: the next dump begins only from IDLE after DONE
        push_dump(6, 7);
        push_dump(6, 7);
        first_addr = 3'd6; last_addr = 3'd7;
        start = 1'b1;
        wait_done(100);
        chk("held_idle_busy", busy, 0);
        chk("held_idle_done", done, 0);
        @(posedge clk); #1;
        chk("held_restart", busy, 1);
        start = 1'b0;
        wait_done(100);
        chk("held_q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
